// File: rtl/add_round_key_pipe.sv
// Registered AddRoundKey stage with a local round-key bank and a 1-deep valid/ready output slot.
// Optional decrypt indexing (NUM_KEYS-1-i_round) is enabled by defining ADD_ROUND_KEY_DEC_EN.
module add_round_key_pipe #(
    parameter int DATA_W   = 128,
    parameter int NUM_KEYS = 11,
    parameter int IDX_W    = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rekey,
    input  logic              i_key_valid,
    input  logic [DATA_W-1:0] i_key,
    output logic              o_key_ready,
    output logic              o_keys_loaded,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_state,
    input  logic [IDX_W-1:0]  i_round,
`ifdef ADD_ROUND_KEY_DEC_EN
    input  logic              i_dec,
`endif
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_state,
    output logic [IDX_W-1:0]  o_round,
    output logic              o_round_err,
    input  logic              i_ready
);

    localparam logic [0:0]       ST_LOAD  = 1'b0;
    localparam logic [0:0]       ST_RUN   = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

    logic [0:0]        fsm_q, fsm_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              key_we;
    logic [DATA_W-1:0] key_mem [NUM_KEYS];

    logic              accept;
    logic              round_err;
    logic [IDX_W-1:0]  key_idx;
    logic [DATA_W-1:0] result;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_state_q, out_state_d;
    logic [IDX_W-1:0]  out_round_q, out_round_d;
    logic              out_err_q,   out_err_d;

    // Key loading: a rekey in LOAD rewinds the pointer and drops the beat offered with it.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        fsm_d  = fsm_q;
        ptr_d  = ptr_q;
        key_we = 1'b0;
        case (fsm_q)
            ST_LOAD: begin
                if (i_rekey) begin
                    ptr_d = '0;
                end else if (i_key_valid) begin
                    key_we = 1'b1;
                    if (ptr_q == LAST_IDX) begin
                        fsm_d = ST_RUN;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (i_rekey) begin
                    fsm_d = ST_LOAD;
                    ptr_d = '0;
                end
            end
            default: begin
                fsm_d = ST_LOAD;
                ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            fsm_q <= ST_LOAD;
            ptr_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            ptr_q <= ptr_d;
        end
    end

    // NOTE: the key bank has no reset; it is a plain RAM and is only read after a full load.
    always_ff @(posedge i_clk) begin
        if (key_we && !i_rst) begin
            key_mem[ptr_q] <= i_key;
        end
    end

    assign o_key_ready   = (fsm_q == ST_LOAD);
    assign o_keys_loaded = (fsm_q == ST_RUN);
    assign o_ready       = (fsm_q == ST_RUN) && (!out_valid_q || i_ready);
    assign accept        = i_valid && o_ready;

    assign round_err = (32'(i_round) >= NUM_KEYS);
`ifdef ADD_ROUND_KEY_DEC_EN
    assign key_idx = i_dec ? (LAST_IDX - i_round) : i_round;
`else
    assign key_idx = i_round;
`endif
    assign result = round_err ? i_state : (i_state ^ key_mem[key_idx]);

    // Output slot: load on accept, clear when consumed with nothing new, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        out_round_d = out_round_q;
        out_err_d   = out_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_state_d = result;
            out_round_d = i_round;
            out_err_d   = round_err;
        end else if (out_valid_q && i_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            out_round_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            out_round_q <= out_round_d;
            out_err_q   <= out_err_d;
        end
    end

    assign o_valid     = out_valid_q;
    assign o_state     = out_state_q;
    assign o_round     = out_round_q;
    assign o_round_err = out_err_q;

endmodule

// File: tb/tb_add_round_key_pipe.sv
// Directed bench for add_round_key_pipe using the FIPS-197 AES-128 key schedule.
module tb_add_round_key_pipe;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_rekey;
    logic         i_key_valid;
    logic [127:0] i_key;
    logic         o_key_ready;
    logic         o_keys_loaded;
    logic         i_valid;
    logic [127:0] i_state;
    logic [3:0]   i_round;
    logic         o_ready;
    logic         o_valid;
    logic [127:0] o_state;
    logic [3:0]   o_round;
    logic         o_round_err;
    logic         i_ready;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    add_round_key_pipe #(.DATA_W(128), .NUM_KEYS(11), .IDX_W(4)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rekey      (i_rekey),
        .i_key_valid  (i_key_valid),
        .i_key        (i_key),
        .o_key_ready  (o_key_ready),
        .o_keys_loaded(o_keys_loaded),
        .i_valid      (i_valid),
        .i_state      (i_state),
        .i_round      (i_round),
`ifdef ADD_ROUND_KEY_DEC_EN
        .i_dec        (1'b0),
`endif
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .o_state      (o_state),
        .o_round      (o_round),
        .o_round_err  (o_round_err),
        .i_ready      (i_ready)
    );

    logic [127:0] keys [11];

    typedef struct {
        logic [127:0] st;
        logic [3:0]   rnd;
        logic [127:0] exp_st;
        logic         exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load_keys(input int n, input logic inv);
        for (int i = 0; i < n; i++) begin
            i_key_valid = 1'b1;
            i_key       = inv ? ~keys[i] : keys[i];
            #1;
            check("load_key_ready", o_key_ready, 1);
            check("load_not_loaded", o_keys_loaded, 0);
            check("load_no_data_ready", o_ready, 0);
            tick();
        end
        i_key_valid = 1'b0;
    endtask

    initial begin
        keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 4'd0,
                    128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0};
        vecs[1] = '{128'h0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0};
        vecs[2] = '{128'h0123456789abcdef0123456789abcdef, 4'd12,
                    128'h0123456789abcdef0123456789abcdef, 1'b1};
        vecs[3] = '{128'hffffffffffffffffffffffffffffffff, 4'd5,
                    128'h2b2e3907837c6278350d4743ee06ea43, 1'b0};
        vecs[4] = '{128'h0, 4'd15, 128'h0, 1'b1};
        vecs[5] = '{128'h0, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0};
        vecs[6] = '{128'hac7766f319fadc2128d12941575c006e, 4'd9, 128'h0, 1'b0};

        i_rst = 1'b1; i_rekey = 1'b0; i_key_valid = 1'b0; i_key = '0;
        i_valid = 1'b0; i_state = '0; i_round = '0; i_ready = 1'b1;
        tick();
        tick();
        check("rst_key_ready", o_key_ready, 1);
        check("rst_keys_loaded", o_keys_loaded, 0);
        check("rst_ready", o_ready, 0);
        check("rst_valid", o_valid, 0);
        check("rst_state", o_state, 0);
        check("rst_round", o_round, 0);
        check("rst_round_err", o_round_err, 0);
        i_rst = 1'b0;

        // Reset in the middle of a load forces a complete reload.
        load_keys(5, 1'b0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        #1;
        check("midload_rst_loaded", o_keys_loaded, 0);
        check("midload_rst_valid", o_valid, 0);
        check("midload_rst_key_ready", o_key_ready, 1);

        load_keys(11, 1'b0);
        check("loaded_after_11", o_keys_loaded, 1);
        check("key_ready_after_11", o_key_ready, 0);
        check("ready_after_11", o_ready, 1);

        // Streamed vectors at full throughput.
        i_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            i_valid = 1'b1;
            i_state = vecs[v].st;
            i_round = vecs[v].rnd;
            #1;
            check("vec_ready", o_ready, 1);
            tick();
            check("vec_valid", o_valid, 1);
            check("vec_state", o_state, vecs[v].exp_st);
            check("vec_round", o_round, 128'(vecs[v].rnd));
            check("vec_round_err", o_round_err, 128'(vecs[v].exp_err));
        end
        i_valid = 1'b0;
        tick();
        check("drain_valid", o_valid, 0);

        // Back-pressure: A is held for three cycles while B waits.
        i_ready = 1'b0;
        i_valid = 1'b1; i_state = '0; i_round = 4'd2;
        tick();
        i_round = 4'd3;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_valid", o_valid, 1);
            check("stall_state", o_state, keys[2]);
            check("stall_round", o_round, 2);
            check("stall_ready", o_ready, 0);
            if (c < 2) tick();
        end
        i_ready = 1'b1;
        #1;
        check("release_ready", o_ready, 1);
        tick();
        check("after_stall_b", o_state, keys[3]);
        check("after_stall_b_round", o_round, 3);
        i_round = 4'd4;
        tick();
        check("after_stall_c", o_state, keys[4]);
        check("after_stall_c_valid", o_valid, 1);
        i_valid = 1'b0;
        tick();
        check("after_stall_drain", o_valid, 0);

        // Rekey together with a data accept: the beat uses the old key.
        i_valid = 1'b1; i_state = '0; i_round = 4'd7; i_rekey = 1'b1;
        #1;
        check("rekey_accept_ready", o_ready, 1);
        tick();
        i_rekey = 1'b0; i_ready = 1'b0;
        #1;
        check("rekey_old_key", o_state, keys[7]);
        check("rekey_out_valid", o_valid, 1);
        check("rekey_ready_low", o_ready, 0);
        check("rekey_loaded_low", o_keys_loaded, 0);
        check("rekey_key_ready", o_key_ready, 1);
        tick();
        check("rekey_held_valid", o_valid, 1);
        check("rekey_held_state", o_state, keys[7]);
        i_valid = 1'b0; i_ready = 1'b1;
        tick();
        check("rekey_consumed", o_valid, 0);

        // Rekey in LOAD discards the coincident beat and rewinds the pointer.
        load_keys(3, 1'b1);
        i_key_valid = 1'b1; i_key = 128'hdeadbeef; i_rekey = 1'b1;
        tick();
        i_key_valid = 1'b0; i_rekey = 1'b0;
        load_keys(11, 1'b1);
        check("reload_loaded", o_keys_loaded, 1);
        check("reload_key_ready", o_key_ready, 0);

        i_valid = 1'b1; i_state = '0; i_round = 4'd7;
        tick();
        check("new_key7", o_state, ~keys[7]);
        i_round = 4'd0;
        tick();
        check("new_key0", o_state, ~keys[0]);

        // Reset while an output is held drops it.
        i_valid = 1'b0; i_ready = 1'b0;
        tick();
        check("pre_rst_held", o_valid, 1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        #1;
        check("midstream_rst_valid", o_valid, 0);
        check("midstream_rst_state", o_state, 0);
        check("midstream_rst_loaded", o_keys_loaded, 0);
        check("midstream_rst_key_ready", o_key_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_round_key_pipe.md
Name: add_round_key_pipe

Overview:
Registered, parametrised AddRoundKey stage holding a full round-key schedule locally. Keys are loaded once through a key-load handshake and stored in an internal key bank. State blocks then stream through a 1-deep valid/ready pipeline that XORs each block with the round key selected by a per-transaction round index. Sits between the key-expansion block and the round datapath; replaces the combinational add_round_key wherever a registered, flow-controlled stage is needed.

Parameters:
DATA_W, 128, width of state and round key in bits
NUM_KEYS, 11, number of stored round keys (Nr+1: 11/13/15 for AES-128/192/256)
IDX_W, 4, width of round index; must satisfy 2^IDX_W >= NUM_KEYS

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous active-high reset
i_rekey  in  1  pulse: discard key bank, return to key loading
i_key_valid  in  1  key beat valid
i_key  in  DATA_W  round key beat; keys loaded in order 0..NUM_KEYS-1
o_key_ready  out  1  key beat accepted when i_key_valid && o_key_ready
o_keys_loaded  out  1  all NUM_KEYS keys stored
i_valid  in  1  input state valid
i_state  in  DATA_W  input state
i_round  in  IDX_W  round-key index for this state
o_ready  out  1  input accepted when i_valid && o_ready
o_valid  out  1  output valid
o_state  out  DATA_W  i_state XOR key[i_round], registered
o_round  out  IDX_W  round index carried with result
o_round_err  out  1  this beat had i_round >= NUM_KEYS
i_ready  in  1  downstream accepts when o_valid && i_ready

Behaviour:
- Reset (i_rst high at edge): state LOAD, write pointer 0, o_keys_loaded 0, o_key_ready 1, o_valid 0, o_state 0, o_round 0, o_round_err 0. Key bank contents are not reset.
- FSM LOAD: o_key_ready=1, o_ready=0. Each accepted key beat writes key[ptr] and increments ptr. When the beat at ptr=NUM_KEYS-1 is accepted, go to RUN next cycle and set o_keys_loaded=1. ptr does not wrap.
- FSM RUN: o_key_ready=0; i_key_valid ignored. o_ready = !o_valid || i_ready, combinational from registered o_valid and i_ready.
- Accept in RUN: next edge o_valid=1, o_state=i_state^key[i_round], o_round=i_round, o_round_err=0. Latency is exactly 1 cycle; full throughput of 1 beat/cycle when i_ready held high.
- i_round >= NUM_KEYS: beat is still accepted; o_state=i_state unchanged, o_round_err=1 for that beat only.
- Output hold: while o_valid && !i_ready, o_state, o_round and o_round_err are stable.
- Output clear: o_valid drops on an edge where o_valid && i_ready and no new accept occurs.
- i_rekey in RUN: next cycle state LOAD, ptr 0, o_keys_loaded 0. A data accept in the same cycle as i_rekey completes using the old keys. Any held output stays valid until consumed.
- i_rekey in LOAD: ptr returns to 0; a key beat accepted in the same cycle is discarded.
- i_rst overrides i_rekey and all handshakes. Reset mid-stream drops the held output.

Optional Feature:
Macro ADD_ROUND_KEY_DEC_EN.
- Defined: adds port i_dec (in, 1), sampled with each accepted data beat. When i_dec=1, the effective index is NUM_KEYS-1-i_round, so decryption can present round numbers ascending. The range check uses raw i_round. o_round reports raw i_round.
- Undefined: no i_dec port; the index is always i_round.

Test Plan:
- Load 11 FIPS-197 AES-128 keys (key0=2b7e151628aed2a6abf7158809cf4f3c, key10=d014f9a8c9ee2589e13f0cc8b6630ca6) -> o_keys_loaded rises the cycle after the 11th beat; o_key_ready=0 afterwards.
- i_state=3243f6a8885a308d313198a2e0370734, i_round=0 -> one cycle later o_valid=1, o_state=193de3bea0f4e22b9ac68d2ae9f84808, o_round=0, o_round_err=0.
- i_state=0, i_round=10 -> o_state=d014f9a8c9ee2589e13f0cc8b6630ca6. i_round=12 with i_state=0123...ef -> o_state=0123...ef, o_round_err=1.
- Back-to-back beats with i_ready low 3 cycles -> o_state held, o_ready=0, no beat lost or duplicated; 1 beat/cycle after i_ready rises.
- i_rekey asserted together with a data accept -> that beat uses old key; o_ready=0 the next cycle; reload with new keys; next result uses new key.
- i_rst mid-load (5 keys) -> o_valid=0, o_keys_loaded=0; full reload of 11 keys is required before o_ready=1.
